// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter definitions: register offsets, STATUS/CTRL bit positions, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_tx_pkg;

    // Register select values for Addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    // STATUS bit positions; the FIFO count occupies bits [7:4]
    localparam int ST_BUSY_BIT  = 0;
    localparam int ST_FULL_BIT  = 1;
    localparam int ST_EMPTY_BIT = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;

    // CTRL bit positions
    localparam int CTRL_TXEN_BIT  = 0;
    localparam int CTRL_IRQEN_BIT = 1;

    // Smallest divisor the baud counter can honour
    localparam logic [15:0] DIV_MIN = 16'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

    // Divisor actually used for a frame: values below DIV_MIN are clamped up
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Transmit byte FIFO with occupancy count.
// Latency: pushed data visible at o_dout the cycle after the push; head read is combinational.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module uart_fifo
    import uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array; no reset needed since count gates every read
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: FIFO-fed 8N1 serialiser with programmable clocks-per-bit.
// Latency: DATA write at edge N drives the start bit after edge N+1; a frame lasts 10*D clocks.
// Backpressure: writes to a full FIFO are dropped and flagged in sticky STATUS.overflow.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_RESET  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_t        r_state;
    tx_state_t        w_state_nxt;
    logic             r_txen;
    logic             r_irqen;
    logic             r_ovf;
    logic [15:0]      r_div;
    logic [15:0]      r_div_lat;
    logic [15:0]      r_baud;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_tick;
    logic [7:0]       w_fifo_dout;
    logic [CNT_W-1:0] w_count;
    logic [3:0]       w_cnt4;
    logic             w_unused_ok;

    assign w_push      = WE && (Addr[3:2] == REG_DATA);
    assign w_tick      = (r_baud == r_div_lat - 16'd1);
    assign w_cnt4      = 4'(w_count);
    assign w_unused_ok = &{1'b0, Addr[31:4], Addr[1:0], Din[31:16]};

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_din   (Din[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Next-state and pop decision; TXEN is only consulted in IDLE so it never cuts a frame
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_txen && !w_empty) begin
                    w_state_nxt = S_START;
                    w_pop       = 1'b1;
                end
            end
            S_START: if (w_tick) w_state_nxt = S_DATA;
            S_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_nxt = S_STOP;
            S_STOP:  if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame datapath: byte and divisor are captured at pop so later register writes cannot disturb the frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift   <= '0;
            r_div_lat <= DIV_MIN;
            r_baud    <= '0;
            r_bit     <= '0;
        end else if (w_pop) begin
            r_shift   <= w_fifo_dout;
            r_div_lat <= eff_div(r_div);
            r_baud    <= '0;
            r_bit     <= '0;
        end else if (r_state != S_IDLE) begin
            if (w_tick) begin
                r_baud <= '0;
                if (r_state == S_DATA) begin
                    r_shift <= r_shift >> 1;
                    r_bit   <= r_bit + 3'd1;
                end
            end else begin
                r_baud <= r_baud + 16'd1;
            end
        end
    end

    // Register writes; a DATA write counts as overflow only if the FIFO cannot take it this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_txen  <= 1'b0;
            r_irqen <= 1'b0;
            r_ovf   <= 1'b0;
            r_div   <= 16'(DIV_RESET);
        end else if (WE) begin
            case (Addr[3:2])
                REG_DATA:   if (w_full && !w_pop) r_ovf <= 1'b1;
                REG_STATUS: r_ovf <= 1'b0;
                REG_CTRL: begin
                    r_txen  <= Din[CTRL_TXEN_BIT];
                    r_irqen <= Din[CTRL_IRQEN_BIT];
                end
                REG_DIV:    r_div <= Din[15:0];
                default:    ;
            endcase
        end
    end

    // Combinational register read mux
    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            REG_STATUS: begin
                Dout[ST_BUSY_BIT]        = (r_state != S_IDLE);
                Dout[ST_FULL_BIT]        = w_full;
                Dout[ST_EMPTY_BIT]       = w_empty;
                Dout[ST_OVF_BIT]         = r_ovf;
                Dout[ST_CNT_LSB +: 4]    = w_cnt4;
            end
            REG_CTRL: begin
                Dout[CTRL_TXEN_BIT]  = r_txen;
                Dout[CTRL_IRQEN_BIT] = r_irqen;
            end
            REG_DIV:  Dout[15:0] = r_div;
            default:  Dout = '0;
        endcase
    end

    // Line and interrupt decode purely from registers, so reset forces txd high immediately
    assign txd = (r_state == S_START) ? 1'b0 :
                 (r_state == S_DATA)  ? r_shift[0] : 1'b1;
    assign IRQ = r_irqen && w_empty && (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: register table, serial-frame scoreboard, multi-cycle corner cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx;
    import uart_tx_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
    } sb_t;

    typedef struct {
        logic [1:0]  reg_sel;
        bit          do_wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    sb_t  sb_q[$];
    int   st_q[$];
    vec_t vecs[10];
    bit   mon_busy    = 1'b0;
    int   frames_done = 0;

    uart_tx #(
        .FIFO_DEPTH (4),
        .DIV_RESET  (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge after the write edge
    task automatic wr(input logic [1:0] r, input logic [31:0] d);
        Addr = {28'h0, r, 2'b00};
        Din  = d;
        WE   = 1'b1;
        @(negedge clk);
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] r, output logic [31:0] d);
        Addr = {28'h0, r, 2'b00};
        #1 d = Dout;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((sb_q.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n = n + 1;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    // Serial monitor: on a start bit, pop the expected byte and check every cycle of the frame
    sb_t        m_e;
    logic [7:0] m_got;
    bit         m_shape;
    bit         m_abort;
    logic       m_expb;
    int         m_idx;
    always begin
        @(negedge clk);
        if (reset === 1'b1 && txd === 1'b0) begin
            mon_busy = 1'b1;
            st_q.push_back(cyc);
            check("frame_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) m_e = sb_q.pop_front();
            else m_e = '{8'h00, 2};
            m_got   = '0;
            m_shape = 1'b1;
            m_abort = 1'b0;
            for (int c = 1; c < 10 * m_e.div; c++) begin
                @(negedge clk);
                if (reset !== 1'b1) begin
                    m_abort = 1'b1;
                    break;
                end
                m_idx = c / m_e.div;
                if (m_idx == 0)      m_expb = 1'b0;
                else if (m_idx == 9) m_expb = 1'b1;
                else                 m_expb = m_e.data[m_idx-1];
                if (txd !== m_expb) m_shape = 1'b0;
                if (m_idx >= 1 && m_idx <= 8 && (c % m_e.div) == (m_e.div / 2))
                    m_got[m_idx-1] = txd;
            end
            if (!m_abort) begin
                check("frame_byte", 32'(m_got), 32'(m_e.data));
                check("frame_shape", 32'(m_shape), 32'd1);
            end
            frames_done++;
            mon_busy = 1'b0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdat;
        int          n;
        int          base;
        int          gap;

        vecs[0] = '{REG_STATUS, 1'b0, 32'h0,        32'h0000_0004, 1'b0};
        vecs[1] = '{REG_CTRL,   1'b0, 32'h0,        32'h0000_0000, 1'b0};
        vecs[2] = '{REG_DIV,    1'b0, 32'h0,        32'h0000_0010, 1'b0};
        vecs[3] = '{REG_DATA,   1'b0, 32'h0,        32'h0000_0000, 1'b0};
        vecs[4] = '{REG_DIV,    1'b1, 32'h1234_ABCD, 32'h0000_ABCD, 1'b0};
        vecs[5] = '{REG_DIV,    1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vecs[6] = '{REG_CTRL,   1'b1, 32'hFFFF_FFFE, 32'h0000_0002, 1'b1};
        vecs[7] = '{REG_CTRL,   1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
        vecs[8] = '{REG_STATUS, 1'b1, 32'hFFFF_FFFF, 32'h0000_0004, 1'b0};
        vecs[9] = '{REG_DIV,    1'b1, 32'h0000_0010, 32'h0000_0010, 1'b0};

        reset = 1'b0;
        WE    = 1'b0;
        Addr  = '0;
        Din   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_irq", 32'(IRQ), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Register map table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_wr) wr(vecs[i].reg_sel, vecs[i].wdata);
            rd(vecs[i].reg_sel, rdat);
            check($sformatf("vec%0d_rd", i), rdat, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(IRQ), 32'(vecs[i].exp_irq));
            @(negedge clk);
        end

        // Single frame 0x55 at D=4: latency and 40-clock busy window
        wr(REG_DIV, 32'd4);
        wr(REG_CTRL, 32'd1);
        sb_q.push_back('{8'h55, 4});
        wr(REG_DATA, 32'h55);
        #1 check("t1_idle_after_write", 32'(txd), 32'd1);
        @(negedge clk);
        #1 check("t1_start_latency", 32'(txd), 32'd0);
        n = 0;
        while (n < 200) begin
            rd(REG_STATUS, rdat);
            if (rdat[0] == 1'b0) break;
            n = n + 1;
            @(negedge clk);
        end
        check("t1_frame_clocks", 32'(n), 32'd40);
        @(negedge clk);
        drain("t1_drain", 200);

        // Overflow with TXEN=0; dropped byte must never appear on the line
        wr(REG_CTRL, 32'd0);
        wr(REG_DIV, 32'd2);
        sb_q.push_back('{8'h11, 2}); wr(REG_DATA, 32'h11);
        sb_q.push_back('{8'h22, 2}); wr(REG_DATA, 32'h22);
        sb_q.push_back('{8'h33, 2}); wr(REG_DATA, 32'h33);
        sb_q.push_back('{8'h44, 2}); wr(REG_DATA, 32'h44);
        wr(REG_DATA, 32'h99);
        rd(REG_STATUS, rdat);
        check("t2_status_ovf", rdat, 32'h0000_004A);
        @(negedge clk);
        wr(REG_STATUS, 32'h0);
        rd(REG_STATUS, rdat);
        check("t2_status_clr", rdat, 32'h0000_0042);
        @(negedge clk);
        wr(REG_CTRL, 32'd1);
        drain("t2_drain", 400);
        repeat (50) @(negedge clk);
        rd(REG_STATUS, rdat);
        check("t2_status_end", rdat, 32'h0000_0004);
        @(negedge clk);

        // IRQ timing around a frame
        wr(REG_CTRL, 32'd3);
        wr(REG_DIV, 32'd2);
        sb_q.push_back('{8'hA5, 2});
        wr(REG_DATA, 32'hA5);
        base = 0;
        n = 0;
        while (n < 100) begin
            rd(REG_STATUS, rdat);
            if (rdat[0] == 1'b0 && rdat[2] == 1'b1) break;
            if (IRQ) base = base + 1;
            n = n + 1;
            @(negedge clk);
        end
        check("t3_irq_low_during_frame", 32'(base), 32'd0);
        check("t3_irq_after_frame", 32'(IRQ), 32'd1);
        @(negedge clk);
        sb_q.push_back('{8'h3C, 2});
        wr(REG_DATA, 32'h3C);
        #1 check("t3_irq_drop_on_write", 32'(IRQ), 32'd0);
        @(negedge clk);
        drain("t3_drain", 200);

        // Divisor change mid-frame applies only to the next frame
        wr(REG_CTRL, 32'd0);
        wr(REG_DIV, 32'd3);
        sb_q.push_back('{8'hC3, 3}); wr(REG_DATA, 32'hC3);
        sb_q.push_back('{8'h3C, 8}); wr(REG_DATA, 32'h3C);
        st_q.delete();
        wr(REG_CTRL, 32'd1);
        n = 0;
        while (st_q.size() == 0 && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        check("t4_frame1_started", 32'(n < 100), 32'd1);
        wr(REG_DIV, 32'd8);
        drain("t4_drain", 400);
        gap = (st_q.size() >= 2) ? (st_q[1] - st_q[0]) : -1;
        check("t4_start_gap", 32'(gap), 32'd31);

        // DIVISOR=0 clamps to 2; write while full coincides with a pop
        wr(REG_CTRL, 32'd0);
        wr(REG_DIV, 32'd0);
        rd(REG_DIV, rdat);
        check("t5_div_raw", rdat, 32'd0);
        @(negedge clk);
        sb_q.push_back('{8'h01, 2}); wr(REG_DATA, 32'h01);
        sb_q.push_back('{8'h80, 2}); wr(REG_DATA, 32'h80);
        sb_q.push_back('{8'hF7, 2}); wr(REG_DATA, 32'hF7);
        sb_q.push_back('{8'h6E, 2}); wr(REG_DATA, 32'h6E);
        sb_q.push_back('{8'h5A, 2});
        base = frames_done;
        st_q.delete();
        wr(REG_CTRL, 32'd1);
        wr(REG_DATA, 32'h5A);
        rd(REG_STATUS, rdat);
        check("t5_status_pop_push", rdat, 32'h0000_0043);
        @(negedge clk);
        wr(REG_CTRL, 32'd0);
        n = 0;
        while (frames_done == base && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        repeat (10) @(negedge clk);
        rd(REG_STATUS, rdat);
        check("t5_txen_off_holds", rdat, 32'h0000_0042);
        @(negedge clk);
        wr(REG_CTRL, 32'd1);
        drain("t5_drain", 400);
        gap = (st_q.size() >= 3) ? (st_q[2] - st_q[1]) : -1;
        check("t5_b2b_gap", 32'(gap), 32'd21);

        // Reset during DATA bit 3
        wr(REG_CTRL, 32'd3);
        wr(REG_DIV, 32'd4);
        sb_q.push_back('{8'hF0, 4});
        base = st_q.size();
        wr(REG_DATA, 32'hF0);
        n = 0;
        while (st_q.size() == base && n < 100) begin
            @(negedge clk);
            n = n + 1;
        end
        repeat (17) @(negedge clk);
        check("t6_bit3_low", 32'(txd), 32'd0);
        reset = 1'b0;
        #1;
        check("t6_txd_async", 32'(txd), 32'd1);
        check("t6_irq_async", 32'(IRQ), 32'd0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd(REG_STATUS, rdat);
        check("t6_status", rdat, 32'h0000_0004);
        rd(REG_DIV, rdat);
        check("t6_div", rdat, 32'h0000_0010);
        rd(REG_CTRL, rdat);
        check("t6_ctrl", rdat, 32'h0000_0000);
        check("t6_irq", 32'(IRQ), 32'd0);
        repeat (50) @(negedge clk);
        check("t6_no_stray_frame", 32'(mon_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
